pla_vec_stage: RTL and testbench
================================

Name: pla_vec_stage

Overview:
- Sequential vector-application stage that sits directly upstream of a 12-input, single-output combinational PLA cone (inputs x0..x11, output y0).
- Accepts test vectors over a valid/ready handshake and drives them as registered inputs to the cone.
- Waits a programmable settle time, then samples y0 and compares it against an expected bit.
- Returns the result downstream over a second valid/ready handshake and keeps saturating vector and error counters.

Parameters:
- N_IN, 12: cone input width; x_drv[i] drives cone input xi.
- SETTLE, 2: number of cycles from vector acceptance to y sample. Legal range is 1..15.
- CNT_W, 16: width of vec_cnt and err_cnt.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  stage can accept a vector.
- in_vec  in  N_IN  vector to apply.
- in_exp  in  1  expected cone output for in_vec.
- x_drv  out  N_IN  registered drive to the cone; bit i goes to xi.
- y_in  in  1  cone output y0, combinational from x_drv.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_y  out  1  sampled y0.
- out_mis  out  1  out_y XOR expected.
- vec_cnt  out  CNT_W  number of vectors evaluated.
- err_cnt  out  CNT_W  number of mismatches.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: one clock, rst synchronous active-high. On reset:
  - state = IDLE
  - x_drv = 0, out_valid = 0, out_y = 0, out_mis = 0
  - vec_cnt = 0, err_cnt = 0, settle counter = 0
  - in_ready = 1 from the first cycle after reset.
- in_ready = (state == IDLE), driven combinationally from the state register.
- Three states: IDLE, SETTLE, HOLD.
- IDLE:
  - On in_valid & in_ready at edge k: x_drv <= in_vec, exp_r <= in_exp, scnt <= 0, state -> SETTLE.
  - in_valid without ready (any other state) is ignored; upstream must hold in_vec/in_exp stable until accepted.
- SETTLE:
  - scnt increments every cycle. x_drv is constant.
  - At the edge where scnt == SETTLE-1 (edge k+SETTLE):
    - out_y <= y_in
    - out_mis <= y_in ^ exp_r
    - out_valid <= 1
    - vec_cnt += 1
    - err_cnt += (y_in ^ exp_r)
    - state -> HOLD
  - Resulting latency from acceptance edge to out_valid high: SETTLE cycles. SETTLE=1 samples one cycle after x_drv updates.
- HOLD:
  - out_valid, out_y and out_mis are held stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0, state -> IDLE.
  - No bypass: a new vector cannot be accepted in the same cycle as the result handoff. Back-to-back throughput is one vector per SETTLE+2 cycles with out_ready tied high.
- x_drv keeps the last applied vector while IDLE. It never returns to 0 except on reset.
- Counters saturate at 2^CNT_W-1 and never wrap. err_cnt may saturate independently of vec_cnt.
- Reset during SETTLE or HOLD: the pending result is discarded and all reset values apply on the next cycle. No out_valid pulse is emitted.
- Simultaneous rst and in_valid: rst wins and the vector is not accepted.

Optional Feature:
- Macro: PLA_VEC_EXHAUSTIVE_GEN_EN.
- When defined, two extra ports are added:
  - start  in  1
  - done  out  1  (reset value 0)
- A start pulse in IDLE begins an internal sweep:
  - Vectors 0 .. 2^N_IN-1 are applied in ascending order, each through SETTLE and HOLD as normal.
  - in_vec and in_exp are ignored during the sweep; expected is forced to 0, so err_cnt counts ON-set minterms.
  - in_ready is low for the whole sweep.
  - done pulses high for one cycle after the last result handoff, then the block returns to IDLE.
  - start is ignored outside IDLE.
- When the macro is undefined, the ports and generator logic are absent and behaviour is exactly as above.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid=1 -> in_ready=1, x_drv=0, out_valid=0, vec_cnt=0, err_cnt=0. No vector is accepted.
- Single vector: stub y_in = x_drv[0] & x_drv[9] & ~x_drv[1]; SETTLE=2; in_vec=12'h201, in_exp=1 -> out_valid rises 2 cycles after acceptance, out_y=1, out_mis=0, vec_cnt=1, err_cnt=0.
- Mismatch and back-pressure: in_vec=12'h203, in_exp=1 (stub gives 0); out_ready held low 5 cycles -> out_valid, out_y=0 and out_mis=1 stay stable; in_ready=0 throughout; err_cnt=1; IDLE one cycle after out_ready.
- Saturation: CNT_W=2, 5 mismatching vectors -> vec_cnt=3, err_cnt=3, no wrap.
- Reset mid-SETTLE: SETTLE=4, assert rst at scnt=2 -> no out_valid pulse, counters 0, x_drv=0, in_ready=1 next cycle.
- With PLA_VEC_EXHAUSTIVE_GEN_EN and N_IN=4, same stub on bits 0/1 -> 16 results in order 0..15, vec_cnt=16, err_cnt equals the stub's ON-set count, done pulses once.

Source files
------------

// File: rtl/pla_vec_stage.sv
// Vector-application stage for a 12-input single-output PLA cone: applies vectors, waits a
// settle time, samples y0 and reports match/mismatch. Optional sweep generator: PLA_VEC_EXHAUSTIVE_GEN_EN.
module pla_vec_stage #(
  parameter int N_IN   = 12,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             in_exp,
  output logic [N_IN-1:0]  x_drv,
  input  logic             y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic             out_mis,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
`ifdef PLA_VEC_EXHAUSTIVE_GEN_EN
  ,
  input  logic             start,
  output logic             done
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] scnt;
  logic       exp_r;
  logic       mis;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  assign mis  = y_in ^ exp_r;
  assign busy = (state != ST_IDLE);

`ifdef PLA_VEC_EXHAUSTIVE_GEN_EN
  logic            gen_active;
  logic [N_IN-1:0] gen_vec;

  assign in_ready = (state == ST_IDLE) && !gen_active;

  // Main control: handshake FSM, sampling, counters and the sweep generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      scnt       <= 4'd0;
      exp_r      <= 1'b0;
      x_drv      <= {N_IN{1'b0}};
      out_valid  <= 1'b0;
      out_y      <= 1'b0;
      out_mis    <= 1'b0;
      vec_cnt    <= {CNT_W{1'b0}};
      err_cnt    <= {CNT_W{1'b0}};
      gen_active <= 1'b0;
      gen_vec    <= {N_IN{1'b0}};
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gen_active) begin
            // Sweep owns the cone; expected forced low so err_cnt counts the ON-set.
            x_drv <= gen_vec;
            exp_r <= 1'b0;
            scnt  <= 4'd0;
            state <= ST_SETTLE;
          end else if (start) begin
            gen_active <= 1'b1;
            gen_vec    <= {N_IN{1'b0}};
          end else if (in_valid) begin
            x_drv <= in_vec;
            exp_r <= in_exp;
            scnt  <= 4'd0;
            state <= ST_SETTLE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          scnt <= scnt + 4'd1;
          if (scnt == SETTLE_LAST) begin
            out_y     <= y_in;
            out_mis   <= mis;
            out_valid <= 1'b1;
            vec_cnt   <= sat_inc(vec_cnt, 1'b1);
            err_cnt   <= sat_inc(err_cnt, mis);
            state     <= ST_HOLD;
          end else begin
            state <= ST_SETTLE;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
            if (gen_active) begin
              if (gen_vec == {N_IN{1'b1}}) begin
                gen_active <= 1'b0;
                done       <= 1'b1;
              end else begin
                gen_vec <= gen_vec + N_IN'(1);
              end
            end else begin
              gen_vec <= gen_vec;
            end
          end else begin
            state <= ST_HOLD;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
`else
  assign in_ready = (state == ST_IDLE);

  // Main control: handshake FSM, sampling and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      scnt      <= 4'd0;
      exp_r     <= 1'b0;
      x_drv     <= {N_IN{1'b0}};
      out_valid <= 1'b0;
      out_y     <= 1'b0;
      out_mis   <= 1'b0;
      vec_cnt   <= {CNT_W{1'b0}};
      err_cnt   <= {CNT_W{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_drv <= in_vec;
            exp_r <= in_exp;
            scnt  <= 4'd0;
            state <= ST_SETTLE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          scnt <= scnt + 4'd1;
          if (scnt == SETTLE_LAST) begin
            out_y     <= y_in;
            out_mis   <= mis;
            out_valid <= 1'b1;
            vec_cnt   <= sat_inc(vec_cnt, 1'b1);
            err_cnt   <= sat_inc(err_cnt, mis);
            state     <= ST_HOLD;
          end else begin
            state <= ST_SETTLE;
          end
        end
        ST_HOLD: begin
          // No bypass: the next vector is taken only after a cycle back in IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            state <= ST_HOLD;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_pla_vec_stage.sv
// Directed self-checking bench for pla_vec_stage with a small AND-cone stub on y_in.
module tb_pla_vec_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // u0: default configuration (SETTLE=2, CNT_W=16)
  logic        rst0, in_valid0, in_ready0, in_exp0, out_valid0, out_ready0, out_y0, out_mis0, busy0, y0;
  logic [11:0] in_vec0, x_drv0;
  logic [15:0] vec_cnt0, err_cnt0;

  // u1: SETTLE=4, CNT_W=2 for saturation and mid-settle reset
  logic        rst1, in_valid1, in_ready1, in_exp1, out_valid1, out_ready1, out_y1, out_mis1, busy1, y1;
  logic [11:0] in_vec1, x_drv1;
  logic [1:0]  vec_cnt1, err_cnt1;

  assign y0 = x_drv0[0] & x_drv0[9] & ~x_drv0[1];
  assign y1 = x_drv1[0] & x_drv1[9] & ~x_drv1[1];

`ifdef PLA_VEC_EXHAUSTIVE_GEN_EN
  logic start0 = 1'b0, done0, start1 = 1'b0, done1;
  // u2: N_IN=4 sweep instance
  logic        rst2, in_valid2, in_ready2, in_exp2, out_valid2, out_ready2, out_y2, out_mis2, busy2, y2;
  logic        start2, done2;
  logic [3:0]  in_vec2, x_drv2;
  logic [15:0] vec_cnt2, err_cnt2;
  assign y2 = x_drv2[0] & ~x_drv2[1];

  pla_vec_stage #(.N_IN(4), .SETTLE(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .in_vec(in_vec2),
    .in_exp(in_exp2), .x_drv(x_drv2), .y_in(y2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_y(out_y2), .out_mis(out_mis2), .vec_cnt(vec_cnt2), .err_cnt(err_cnt2), .busy(busy2),
    .start(start2), .done(done2));
`endif

  pla_vec_stage #(.N_IN(12), .SETTLE(2), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst0), .in_valid(in_valid0), .in_ready(in_ready0), .in_vec(in_vec0),
    .in_exp(in_exp0), .x_drv(x_drv0), .y_in(y0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_y(out_y0), .out_mis(out_mis0), .vec_cnt(vec_cnt0), .err_cnt(err_cnt0), .busy(busy0)
`ifdef PLA_VEC_EXHAUSTIVE_GEN_EN
    , .start(start0), .done(done0)
`endif
  );

  pla_vec_stage #(.N_IN(12), .SETTLE(4), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1), .in_vec(in_vec1),
    .in_exp(in_exp1), .x_drv(x_drv1), .y_in(y1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_y(out_y1), .out_mis(out_mis1), .vec_cnt(vec_cnt1), .err_cnt(err_cnt1), .busy(busy1)
`ifdef PLA_VEC_EXHAUSTIVE_GEN_EN
    , .start(start1), .done(done1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Push one vector through u1 with out_ready1 high; wait is bounded.
  task automatic run1(input logic [11:0] v, input logic e);
    bit seen;
    in_vec1 = v; in_exp1 = e; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = out_valid1;
    end
    check("u1_result_timeout", 32'(seen), 32'd1);
    tick();
  endtask

  initial begin
    rst0 = 1'b1; in_valid0 = 1'b1; in_vec0 = 12'h201; in_exp0 = 1'b1; out_ready0 = 1'b0;
    rst1 = 1'b1; in_valid1 = 1'b0; in_vec1 = 12'h000; in_exp1 = 1'b0; out_ready1 = 1'b1;
`ifdef PLA_VEC_EXHAUSTIVE_GEN_EN
    rst2 = 1'b1; in_valid2 = 1'b0; in_vec2 = 4'h0; in_exp2 = 1'b1; out_ready2 = 1'b1; start2 = 1'b0;
`endif

    // Reset with in_valid asserted: nothing accepted
    repeat (2) tick();
    check("rst_in_ready", 32'(in_ready0), 32'd1);
    check("rst_x_drv", 32'(x_drv0), 32'd0);
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_vec_cnt", 32'(vec_cnt0), 32'd0);
    check("rst_err_cnt", 32'(err_cnt0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);

    // Single matching vector, SETTLE=2
    rst0 = 1'b0;
    tick();
    in_valid0 = 1'b0;
    check("acc_x_drv", 32'(x_drv0), 32'h201);
    check("acc_in_ready", 32'(in_ready0), 32'd0);
    check("acc_busy", 32'(busy0), 32'd1);
    tick();
    check("lat_early", 32'(out_valid0), 32'd0);
    tick();
    check("lat_valid", 32'(out_valid0), 32'd1);
    check("v1_out_y", 32'(out_y0), 32'd1);
    check("v1_out_mis", 32'(out_mis0), 32'd0);
    check("v1_vec_cnt", 32'(vec_cnt0), 32'd1);
    check("v1_err_cnt", 32'(err_cnt0), 32'd0);
    out_ready0 = 1'b1;
    tick();
    check("v1_handoff_valid", 32'(out_valid0), 32'd0);
    check("v1_idle_ready", 32'(in_ready0), 32'd1);

    // Mismatch with 5 cycles of back-pressure
    out_ready0 = 1'b0; in_vec0 = 12'h203; in_exp0 = 1'b1; in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid0), 32'd1);
      check("bp_out_y", 32'(out_y0), 32'd0);
      check("bp_out_mis", 32'(out_mis0), 32'd1);
      check("bp_in_ready", 32'(in_ready0), 32'd0);
      tick();
    end
    check("v2_vec_cnt", 32'(vec_cnt0), 32'd2);
    check("v2_err_cnt", 32'(err_cnt0), 32'd1);
    out_ready0 = 1'b1;
    tick();
    check("v2_handoff_valid", 32'(out_valid0), 32'd0);
    check("v2_idle_ready", 32'(in_ready0), 32'd1);
    check("v2_x_drv_kept", 32'(x_drv0), 32'h203);

    // Saturation on u1 (CNT_W=2): five mismatches
    rst1 = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) run1(12'h203, 1'b1);
    check("sat_vec_cnt", 32'(vec_cnt1), 32'd3);
    check("sat_err_cnt", 32'(err_cnt1), 32'd3);

    // Reset at scnt=2 with SETTLE=4: pending result discarded
    in_vec1 = 12'h201; in_exp1 = 1'b0; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    repeat (2) tick();
    check("mid_out_valid_pre", 32'(out_valid1), 32'd0);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    check("mid_in_ready", 32'(in_ready1), 32'd1);
    check("mid_x_drv", 32'(x_drv1), 32'd0);
    check("mid_vec_cnt", 32'(vec_cnt1), 32'd0);
    check("mid_err_cnt", 32'(err_cnt1), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("mid_no_pulse", 32'(out_valid1), 32'd0);
      tick();
    end

`ifdef PLA_VEC_EXHAUSTIVE_GEN_EN
    begin
      int n_res;
      int n_done;
      int n_on;
      n_res = 0; n_done = 0; n_on = 0;
      rst2 = 1'b0;
      tick();
      start2 = 1'b1; in_valid2 = 1'b1; in_vec2 = 4'h3;
      tick();
      start2 = 1'b0;
      check("sw_in_ready", 32'(in_ready2), 32'd0);
      for (int c = 0; c < 150; c++) begin
        if (out_valid2) begin
          check("sw_order", 32'(x_drv2), 32'(n_res));
          check("sw_out_y", 32'(out_y2), 32'(n_res[0] & ~n_res[1]));
          if (n_res[0] & ~n_res[1]) n_on++;
          n_res++;
        end
        if (done2) n_done++;
        tick();
      end
      in_valid2 = 1'b0;
      check("sw_results", 32'(n_res), 32'd16);
      check("sw_vec_cnt", 32'(vec_cnt2), 32'd16);
      check("sw_err_cnt", 32'(err_cnt2), 32'(n_on));
      check("sw_onset", 32'(n_on), 32'd4);
      check("sw_done_once", 32'(n_done), 32'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
